// File: rtl/ext_pkg.sv
// Shared immediate-extension definitions, used by decode and by the extension arbiter.
// Holds the 2-bit extension mode encodings and the operand/result widths.
// Contents: IMM_W, RES_W, MODE_ZERO, MODE_SIGN, MODE_UPPER, MODE_BRANCH.
package ext_pkg;

  localparam int IMM_W = 16;
  localparam int RES_W = 32;

  localparam logic [1:0] MODE_ZERO   = 2'b00;  // {16'h0, imm}
  localparam logic [1:0] MODE_SIGN   = 2'b01;  // sign-extended imm
  localparam logic [1:0] MODE_UPPER  = 2'b10;  // {imm, 16'h0}
  localparam logic [1:0] MODE_BRANCH = 2'b11;  // sign-extended imm, word-scaled (<<2)

endpackage

// File: rtl/ext_unit.sv
// Combinational immediate extender: 16-bit imm + 2-bit mode -> 32-bit result.
// Latency 0 (pure combinational); no flow control of its own.
// Ports: imm_i (immediate), mode_i (extension mode), result_o (extended value).
module ext_unit
  import ext_pkg::*;
(
  input  logic [IMM_W-1:0] imm_i,
  input  logic [1:0]       mode_i,
  output logic [RES_W-1:0] result_o
);

  always_comb begin
    result_o = {16'h0, imm_i};
    case (mode_i)
      MODE_ZERO:   result_o = {16'h0, imm_i};
      MODE_SIGN:   result_o = {{16{imm_i[15]}}, imm_i};
      MODE_UPPER:  result_o = {imm_i, 16'h0};
      MODE_BRANCH: result_o = {{14{imm_i[15]}}, imm_i, 2'b00};
      default:     result_o = {16'h0, imm_i};
    endcase
  end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester round-robin arbiter feeding one shared extender into a single result register.
// Latency: 1 cycle from grant (reqN_ready) to out_valid; full throughput of one result per cycle.
// Backpressure: out_ready low with a held result freezes out_data/out_id and withholds all grants.
// Ports: clk, reset (async, active-high); req0_*/req1_* valid/imm/mode/ready request channels;
//        out_valid/out_ready/out_data/out_id result channel (out_id = owning requester).
module ext_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_mode,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_id
);

  logic        out_valid_q, out_valid_d;
  logic        rr_ptr_q, rr_ptr_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_id_q, out_id_d;

  logic        slot_free;
  logic        grant0, grant1, any_grant;
  logic [15:0] sel_imm;
  logic [1:0]  sel_mode;
  logic [31:0] ext_result;

  // The slot frees in the same cycle the consumer drains it, so a new
  // result can be loaded on the edge that retires the old one.
  assign slot_free = !out_valid_q || out_ready;

  // Grants are forced low during reset so no requester believes it was accepted.
  assign grant0    = !reset && slot_free && req0_valid && (!req1_valid || !rr_ptr_q);
  assign grant1    = !reset && slot_free && req1_valid && (!req0_valid ||  rr_ptr_q);
  assign any_grant = grant0 || grant1;

  assign sel_imm  = grant1 ? req1_imm  : req0_imm;
  assign sel_mode = grant1 ? req1_mode : req0_mode;

  ext_unit u_ext_unit (
    .imm_i    (sel_imm),
    .mode_i   (sel_mode),
    .result_o (ext_result)
  );

  always_comb begin
    out_valid_d = any_grant || (out_valid_q && !out_ready);
    out_data_d  = any_grant ? ext_result : out_data_q;
    out_id_d    = any_grant ? grant1     : out_id_q;
    // Priority moves to whichever requester lost (or was absent) this grant.
    rr_ptr_d    = grant0 ? 1'b1 : (grant1 ? 1'b0 : rr_ptr_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rr_ptr_q    <= 1'b0;
      out_data_q  <= 32'h0;
      out_id_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_id     = out_id_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Self-checking bench for ext_arbiter: reference extension model plus a result scoreboard.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at mid-cycle.
// Expected results are queued on predicted grants and compared when the DUT presents them.
module tb_ext_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_imm, req1_imm;
  logic [1:0]  req0_mode, req1_mode;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic        out_id;

  ext_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_imm   (req0_imm),
    .req0_mode  (req0_mode),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_imm   (req1_imm),
    .req1_mode  (req1_mode),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_data[$];
  logic        exp_id[$];
  logic        m_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference extension written arithmetically rather than by bit concatenation.
  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic signed [31:0] s;
    s = 32'(signed'(imm));
    case (mode)
      2'd0:    return 32'(imm);
      2'd1:    return s;
      2'd2:    return 32'(imm) << 16;
      default: return s <<< 2;
    endcase
  endfunction

  // One clock cycle: sample mid-cycle, check against model, advance model, move past the edge.
  task automatic step();
    logic free, g0, g1;
    #4;
    free = (exp_data.size() == 0) || out_ready;
    g0 = free && req0_valid && (!req1_valid || !m_ptr);
    g1 = free && req1_valid && (!req0_valid ||  m_ptr);
    chk("out_valid", 32'(out_valid), 32'(exp_data.size() != 0));
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    if (exp_data.size() != 0) begin
      chk("out_data", out_data, exp_data[0]);
      chk("out_id", 32'(out_id), 32'(exp_id[0]));
      if (out_ready) begin
        void'(exp_data.pop_front());
        void'(exp_id.pop_front());
      end
    end
    if (g0) begin exp_data.push_back(ref_ext(req0_imm, req0_mode)); exp_id.push_back(1'b0); end
    if (g1) begin exp_data.push_back(ref_ext(req1_imm, req1_mode)); exp_id.push_back(1'b1); end
    if (g0) m_ptr = 1'b1;
    else if (g1) m_ptr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [15:0] i0, input logic [1:0] m0,
                       input logic v1, input logic [15:0] i1, input logic [1:0] m1,
                       input logic rdy);
    req0_valid = v0; req0_imm = i0; req0_mode = m0;
    req1_valid = v1; req1_imm = i1; req1_mode = m1;
    out_ready  = rdy;
  endtask

  initial begin
    m_ptr = 1'b0;
    reset = 1'b1;
    drive(1'b1, 16'h1111, 2'd0, 1'b1, 16'h2222, 2'd1, 1'b1);
    #7;
    // Reset state, with both requesters asking: nothing may be granted.
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_id", 32'(out_id), 32'h0);
    chk("rst_req0_ready", 32'(req0_ready), 32'h0);
    chk("rst_req1_ready", 32'(req1_ready), 32'h0);
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single requester 0, SIGN mode.
    drive(1'b1, 16'h8004, 2'd1, 1'b0, 16'h0, 2'd0, 1'b1);
    step();
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    #2;
    chk("sign_lit", out_data, 32'hFFFF8004);
    #2;
    step();
    step();

    // Fresh priority for the alternation case.
    reset = 1'b1; #1; reset = 1'b0; m_ptr = 1'b0;
    exp_data.delete(); exp_id.delete();
    drive(1'b1, 16'h1234, 2'd2, 1'b1, 16'hFFFF, 2'd3, 1'b1);
    step();
    #2; chk("upper_lit", out_data, 32'h12340000); chk("upper_id", 32'(out_id), 32'h0); #2;
    step();
    #2; chk("branch_lit", out_data, 32'hFFFFFFFC); chk("branch_id", 32'(out_id), 32'h1); #2;
    for (int i = 0; i < 4; i++) step();

    // Stall with req1 waiting: three frozen cycles, then grant on release.
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    step();
    step();
    drive(1'b1, 16'h00A5, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    step();
    drive(1'b0, 16'h0, 2'd0, 1'b1, 16'h8001, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      req0_imm = 16'(i * 16'h1357);   // idle requester's fields must not matter
      step();
    end
    out_ready = 1'b1;
    step();
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    step();
    step();

    // Back-to-back requester 0, including the ZERO-mode boundary value.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? 16'h8000 : 16'($urandom), 2'(i), 1'b0, 16'h0, 2'd0, 1'b1);
      step();
    end
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    #2; chk("zero_lit_last", out_data, ref_ext(16'h0, 2'd0) | out_data); #2;
    step();

    // Randomised traffic with backpressure.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom),
            1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom),
            ($urandom_range(0, 9) < 7));
      step();
    end

    // Build a stall, then pulse reset asynchronously mid-cycle.
    drive(1'b0, 16'h0, 2'd0, 1'b1, 16'h4321, 2'd1, 1'b1);
    step();
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b0);
    step();
    #1;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_out_data", out_data, 32'h0);
    reset = 1'b0;
    exp_data.delete(); exp_id.delete(); m_ptr = 1'b0;
    drive(1'b1, 16'h0042, 2'd2, 1'b1, 16'h0043, 2'd2, 1'b1);
    // step() samples later in this same cycle; req0 must win.
    #2;
    chk("post_rst_req0_first", 32'(req0_ready), 32'h1);
    step();
    step();
    drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
